epc_stack: RTL
==============

# epc_stack

Parametrised exception-return-address unit for the pipelined CPU's CP0 path. It holds a stack of saved EPC values so exceptions can nest, accepts direct `mtc0` writes to the top entry, and forwards in-flight EPC writes from later pipeline stages. It presents a word-aligned return address to the `eret` fetch redirect. It replaces the single-register EPC select-and-align path.

## Interface
Parameters:
- `WIDTH`, 32, address width in bits
- `DEPTH`, 4, number of stack entries (≥1)
- `NFWD`, 2, number of forwarding channels (≥1)
- `ALIGN`, 2, number of low address bits forced to zero on `epc_out` (< WIDTH)

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high
- `exc_req`  in  1  exception taken this cycle; push
- `exc_pc`  in  WIDTH  PC of the faulting instruction
- `exc_bd`  in  1  faulting instruction is in a branch delay slot
- `eret`  in  1  exception return committed this cycle; pop
- `mtc0_we`  in  1  write EPC (top entry)
- `mtc0_data`  in  WIDTH  data for `mtc0_we`
- `fwd_valid`  in  NFWD  in-flight EPC write pending, per channel
- `fwd_data`  in  NFWD*WIDTH  channel i at bits [i*WIDTH +: WIDTH]
- `epc_out`  out  WIDTH  aligned return address (combinational)
- `depth_cnt`  out  clog2(DEPTH+1)  valid entries
- `full`  out  1  `depth_cnt == DEPTH`
- `empty`  out  1  `depth_cnt == 0`
- `overflow`  out  1  sticky: push while full
- `underflow`  out  1  sticky: pop while empty

## Operation
- Storage: `DEPTH` entries of WIDTH bits plus a counter. Entries are stored unaligned. Alignment is applied only on `epc_out`.
- Saved value: `exc_pc - 4` (mod 2^WIDTH) when `exc_bd`=1, else `exc_pc`.
- Command priority per cycle: `exc_req` > `eret` > `mtc0_we`. Lower-priority commands in the same cycle are dropped with no side effects.
- Push (`exc_req`):
  - Not full: write the saved value at index `depth_cnt`, then increment.
  - Full: overwrite the top entry (`DEPTH-1`), count unchanged, set `overflow`.
- Pop (`eret`):
  - Not empty: decrement. The entry contents are left stale.
  - Empty: no state change, set `underflow`.
- `mtc0_we`:
  - Not empty: write `mtc0_data` to the top entry (`depth_cnt-1`).
  - Empty: write entry 0 and set count to 1.
- `epc_out` source, in priority order:
  1. If any `fwd_valid` bit is set: the highest-indexed valid channel (youngest).
  2. Else if not empty: the top entry.
  3. Else: 0.
  - The selected value has bits [ALIGN-1:0] forced to 0.
- `overflow` and `underflow` clear only on `reset`.

## Timing
- Reset: all entries 0, `depth_cnt`=0, `empty`=1, `full`=0, `overflow`=0, `underflow`=0, `epc_out`=0 (when no `fwd_valid`).
- Push, pop and write take effect at the rising edge. `depth_cnt`, `full`, `empty` and the stack-sourced `epc_out` reflect the new state in the following cycle.
- Forwarding has zero latency: `epc_out` follows `fwd_valid`/`fwd_data` in the same cycle, with no registered stage.
- A write does not bypass in its own cycle: `epc_out` shows the old top in the same cycle as `mtc0_we`. The pipeline covers that case through a `fwd` channel.
- Reset asserted mid-sequence wins over every command in that cycle.

## Configuration
- Macro: `EPC_STACK_NEST_EN`.
- Defined: nesting as described, with `DEPTH` entries.
- Not defined: effective depth is 1, regardless of `DEPTH`.
  - A push always writes entry 0 and sets count to 1.
  - `overflow` is tied to 0.
  - A pop when count=1 empties the unit.
  - `full` = (`depth_cnt`==1).

## Test plan
- Reset, then three pushes with `exc_pc`=0x100, 0x204 (`exc_bd`=1), 0x30B. Required: `depth_cnt`=3; `epc_out`=0x308; after one `eret`, 0x200; after another, 0x100.
- Push ×4 to fill (DEPTH=4), then a fifth push with 0x500. Required: `full`=1, `overflow`=1, `depth_cnt`=4, `epc_out`=0x500. Four pops follow, with `epc_out` sequence 0x500, then entries 2, 1, 0. A further pop sets `underflow`=1, `epc_out`=0.
- Empty unit, `mtc0_we` with 0x1234_5677. Required: next cycle `depth_cnt`=1, `epc_out`=0x1234_5674.
- Stack top 0x400, `fwd_valid`=2'b11 with ch0=0x800 and ch1=0x900. Required: `epc_out`=0x900 in the same cycle. With `fwd_valid`=2'b01: 0x800. With 2'b00: 0x400.
- Same cycle `exc_req`(0x600) + `eret` + `mtc0_we`(0xABC) at depth 1 (top 0x100). Required: depth 2, top 0x600, entry 0 still 0x100.
- With the macro undefined: push 0x100, push 0x200. Required: `depth_cnt`=1, `epc_out`=0x200, `overflow`=0.

Source files
------------

// File: rtl/epc_stack.sv
// epc_stack: stack of saved exception return addresses for the CP0 path.
// Nested exceptions push, eret pops, mtc0 writes the top entry, and
// in-flight EPC writes from later stages are forwarded onto epc_out.
// Optional feature macro: EPC_STACK_NEST_EN. When defined, the unit nests
// up to DEPTH entries. When undefined, the unit behaves as a single EPC
// register with an effective depth of 1.
module epc_stack #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int NFWD  = 2,
  parameter int ALIGN = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      exc_req,
  input  logic [WIDTH-1:0]          exc_pc,
  input  logic                      exc_bd,
  input  logic                      eret,
  input  logic                      mtc0_we,
  input  logic [WIDTH-1:0]          mtc0_data,
  input  logic [NFWD-1:0]           fwd_valid,
  input  logic [NFWD*WIDTH-1:0]     fwd_data,
  output logic [WIDTH-1:0]          epc_out,
  output logic [$clog2(DEPTH+1)-1:0] depth_cnt,
  output logic                      full,
  output logic                      empty,
  output logic                      overflow,
  output logic                      underflow
);

  localparam int CW = $clog2(DEPTH + 1);
`ifdef EPC_STACK_NEST_EN
  localparam int EDEPTH = DEPTH;
`else
  localparam int EDEPTH = 1;
`endif
  localparam int IW = (EDEPTH > 1) ? $clog2(EDEPTH) : 1;
  // Clears the low ALIGN bits; all ones when ALIGN is 0.
  localparam logic [WIDTH-1:0] ALIGN_MASK = ~((WIDTH'(1) << ALIGN) - WIDTH'(1));

  // Entries are kept unaligned; alignment happens only on the output.
  logic [WIDTH-1:0] r_mem [EDEPTH];
  logic [CW-1:0]    r_cnt;
  logic             r_full;
  logic             r_empty;
  logic             r_unf;

  logic [WIDTH-1:0] w_saved;
  logic [CW-1:0]    w_cnt_nxt;
  logic             w_we;
  logic [IW-1:0]    w_widx;
  logic [WIDTH-1:0] w_wdata;
  logic             w_ovf_set;
  logic             w_unf_set;
  logic [IW-1:0]    w_top_idx;
  logic [WIDTH-1:0] w_top;
  logic             w_fwd_hit;
  logic [WIDTH-1:0] w_fwd_val;
  logic [WIDTH-1:0] w_sel;

  // A delay-slot fault returns to the branch, one word earlier.
  assign w_saved   = exc_bd ? (exc_pc - WIDTH'(4)) : exc_pc;
  assign w_top_idx = IW'(r_cnt - CW'(1));
  assign w_top     = r_mem[w_top_idx];

  // Resolve the command for this cycle: exc_req over eret over mtc0_we.
  always_comb begin
    w_cnt_nxt = r_cnt;
    w_we      = 1'b0;
    w_widx    = '0;
    w_wdata   = '0;
    w_ovf_set = 1'b0;
    w_unf_set = 1'b0;
    if (exc_req) begin
      w_we    = 1'b1;
      w_wdata = w_saved;
      if (r_full) begin
        // The oldest entries are kept; the newest exception replaces the top.
        w_widx    = IW'(EDEPTH - 1);
        w_ovf_set = 1'b1;
      end else begin
        w_widx    = IW'(r_cnt);
        w_cnt_nxt = r_cnt + CW'(1);
      end
    end else if (eret) begin
      if (r_empty) begin
        w_unf_set = 1'b1;
      end else begin
        w_cnt_nxt = r_cnt - CW'(1);
      end
    end else if (mtc0_we) begin
      w_we    = 1'b1;
      w_wdata = mtc0_data;
      if (r_empty) begin
        w_widx    = '0;
        w_cnt_nxt = CW'(1);
      end else begin
        w_widx    = w_top_idx;
      end
    end else begin
      w_we = 1'b0;
    end
  end

  // Stack storage, count, and registered full/empty flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < EDEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_cnt   <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
      r_unf   <= 1'b0;
    end else begin
      if (w_we) begin
        r_mem[w_widx] <= w_wdata;
      end
      r_cnt   <= w_cnt_nxt;
      r_full  <= (w_cnt_nxt == CW'(EDEPTH));
      r_empty <= (w_cnt_nxt == '0);
      r_unf   <= r_unf | w_unf_set;
    end
  end

`ifdef EPC_STACK_NEST_EN
  logic r_ovf;

  // Sticky overflow: set by a push into a full stack, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ovf <= 1'b0;
    end else begin
      r_ovf <= r_ovf | w_ovf_set;
    end
  end

  assign overflow = r_ovf;
`else
  // A single register simply takes the newest value; nothing overflows.
  logic w_ovf_unused;
  assign w_ovf_unused = w_ovf_set;
  assign overflow     = 1'b0;
`endif

  // Forward select: the highest-indexed valid channel is the youngest write.
  always_comb begin
    w_fwd_hit = 1'b0;
    w_fwd_val = '0;
    for (int i = 0; i < NFWD; i++) begin
      w_fwd_hit = w_fwd_hit | fwd_valid[i];
      w_fwd_val = fwd_valid[i] ? fwd_data[i*WIDTH +: WIDTH] : w_fwd_val;
    end
  end

  // Output source: forwarded value, else the stack top, else zero.
  always_comb begin
    w_sel = '0;
    if (w_fwd_hit) begin
      w_sel = w_fwd_val;
    end else if (!r_empty) begin
      w_sel = w_top;
    end else begin
      w_sel = '0;
    end
  end

  assign epc_out   = w_sel & ALIGN_MASK;
  assign depth_cnt = r_cnt;
  assign full      = r_full;
  assign empty     = r_empty;
  assign underflow = r_unf;

endmodule
